mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_divider.sv | 56 +++++
 rtl/mdu_seq.sv | 144 ++++++++++++++
 tb/tb_mdu_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// op encodings, FSM states, iteration and latency constants.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int DIV_ITERS = 32;
    localparam int MUL_LAT   = 2;
    localparam int DIV_LAT   = 34;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        SIGN,
        DONE
    } state_e;

    // Magnitude of v, treating it as signed only when sgn is set.
    function automatic logic [31:0] mag32(input logic [31:0] v,
                                          input logic        sgn);
        return (sgn && v[31]) ? 32'(-v) : v;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider on 32-bit magnitudes, one quotient bit per step.
// Ports: clk, rst (sync), init (load operands), step (one iteration),
// dividend/divisor magnitudes in, quotient/remainder out.
module mdu_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] trial;

    // The quotient register doubles as the dividend shift register:
    // dividend bits leave at the top while quotient bits enter at the bottom.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        if (init) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (!trial[32]) begin
                rem_d = trial[31:0];
            end else begin
                rem_d = {rem_q[30:0], quo_q[31]};
            end
            quo_d = {quo_q[30:0], ~trial[32]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_seq.sv
// Sequential MDU: single-cycle 32x32 multiply, 32-step restoring divide.
// Ports: clk, rst (sync), start/op/a/b request, cancel flush;
// busy, done pulse and 64-bit {hi,lo} result.
module mdu_seq
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        div_init, div_step;
    logic [31:0] div_quo, div_rem;
    logic [31:0] q_fix, r_fix;
    logic        sgn_mul, sgn_div;
    logic [63:0] mul_a, mul_b, prod;

    // Low 64 bits of the product of the extended operands are exact
    // for both signed and unsigned interpretations.
    assign sgn_mul = (op_q == OP_MULT);
    assign mul_a   = {{32{sgn_mul & a_q[31]}}, a_q};
    assign mul_b   = {{32{sgn_mul & b_q[31]}}, b_q};
    assign prod    = mul_a * mul_b;

    mdu_divider u_div (
        .clk       (clk),
        .rst       (rst),
        .init      (div_init),
        .step      (div_step),
        .dividend  (mag32(a, op == OP_DIV)),
        .divisor   (mag32(b, op == OP_DIV)),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign correction; divide-by-zero overrides the raw iteration output.
    assign sgn_div = (op_q == OP_DIV);
    always_comb begin
        q_fix = div_quo;
        r_fix = div_rem;
        if (sgn_div && (a_q[31] ^ b_q[31])) q_fix = 32'(-div_quo);
        if (sgn_div && a_q[31])             r_fix = 32'(-div_rem);
        if (b_q == '0) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = a_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        done_d   = 1'b0;
        div_init = 1'b0;
        div_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    cnt_d    = '0;
                    div_init = op[1];
                    state_d  = op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    res_d   = prod;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DIV: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_ITERS - 1)) state_d = SIGN;
                end
            end
            SIGN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    res_d   = {r_fix, q_fix};
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, random ops
// against an arithmetic reference, and multi-cycle control sequences.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [63:0] result;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    mdu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy;
        int     qi, ri;
        case (o)
            OP_MULT: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            OP_MULTU: return {32'b0, x} * {32'b0, y};
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (o == OP_DIVU) return {x % y, x / y};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {32'h0, 32'h8000_0000};
                qi = int'(x) / int'(y);
                ri = int'(x) % int'(y);
                return {ri, qi};
            end
        endcase
    endfunction

    // Called at #1 after an edge with the DUT idle; returns the result and
    // the cycle (relative to the accept cycle 0) at which done was seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic [63:0] r,
                          output int n);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        r = result;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string tag, input logic [1:0] o,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] exp, input int lat);
        logic [63:0] r;
        int          n, c0;
        c0 = done_cnt;
        run_op(o, x, y, r, n);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, r, exp);
        chk({tag, "_one_done"}, 64'(done_cnt - c0), 64'd1);
        chk({tag, "_idle"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] last_exp, r;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          n, c0;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,
                    64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,
                    64'h0000_0001_FFFF_FFFE, MUL_LAT};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,
                    {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT};
        vecs[3] = '{OP_DIVU,  32'd100, 32'd7,
                    {32'd2, 32'd14}, DIV_LAT};
        vecs[4] = '{OP_DIVU,  32'd100, 32'd0,
                    {32'h0000_0064, 32'hFFFF_FFFF}, DIV_LAT};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,
                    {32'h0, 32'h8000_0000}, DIV_LAT};
        vecs[6] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,
                    {32'hFFFF_FFF9, 32'hFFFF_FFFF}, DIV_LAT};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000,
                    64'h4000_0000_0000_0000, MUL_LAT};

        // Reset, with start held to show reset wins.
        rst = 1'b1; start = 1'b1; cancel = 1'b0;
        op = OP_DIV; a = 32'd9; b = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_still_idle", {63'b0, busy}, 64'd0);

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                     vecs[i].b, vecs[i].exp, vecs[i].lat);
        end
        last_exp = vecs[7].exp;

        // Random operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            last_exp = model(ro, ra, rb);
            check_op($sformatf("rnd%0d", i), ro, ra, rb, last_exp,
                     ro[1] ? DIV_LAT : MUL_LAT);
        end

        // Cancel at cycle 10 of a DIV, then restart at cycle 11.
        c0 = done_cnt;
        start = 1'b1; op = OP_DIV; a = 32'd1234; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy", {63'b0, busy}, 64'd0);
        chk("cancel_done", {63'b0, done}, 64'd0);
        chk("cancel_result", result, last_exp);
        chk("cancel_no_pulse", 64'(done_cnt - c0), 64'd0);
        run_op(OP_MULTU, 32'd3, 32'd5, r, n);
        chk("restart_lat", 64'(n), 64'(MUL_LAT));
        chk("restart_res", r, 64'd15);

        // Start pulses during a DIV are ignored.
        c0 = done_cnt;
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        for (int i = 1; i <= 33; i++) begin
            start = 1'b1;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ign_done34", {63'b0, done}, 64'd1);
        chk("ign_res", result, {32'd1, 32'd333});
        @(posedge clk); #1;
        chk("ign_one_pulse", 64'(done_cnt - c0), 64'd1);
        chk("ign_idle", {63'b0, busy}, 64'd0);

        // Reset at cycle 5 of a DIV.
        c0 = done_cnt;
        start = 1'b1; op = OP_DIV; a = 32'd50; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_result", result, 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("midrst_no_done", 64'(done_cnt - c0), 64'd0);

        // Back-to-back MULT with start held: IDLE, MUL, DONE repeating.
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        for (int i = 1; i <= 9; i++) begin
            chk($sformatf("b2b_done_c%0d", i), {63'b0, done},
                64'((i % 3) == 2));
            chk($sformatf("b2b_busy_c%0d", i), {63'b0, busy},
                64'((i % 3) != 0));
            if ((i % 3) == 2)
                chk($sformatf("b2b_res_c%0d", i), result,
                    64'hFFFF_FFFF_FFFF_FFFA);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Cancel together with start in IDLE.
        start = 1'b1; cancel = 1'b1; op = OP_MULTU;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        chk("cancel_start_idle", {63'b0, busy}, 64'd0);

        // Cancel during DONE keeps the pulse.
        c0 = done_cnt;
        start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        cancel = 1'b1;
        chk("cdone_done", {63'b0, done}, 64'd1);
        chk("cdone_res", result, 64'd42);
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cdone_idle", {63'b0, busy}, 64'd0);
        chk("cdone_pulse", 64'(done_cnt - c0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
